// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: conditions the start/stop and clear push-buttons
// (2-flop sync, debounce, rising-edge detect), runs the IDLE/RUN/PAUSE state
// machine and produces the count-enable tick and clear pulse for the digit
// counter chain.
module stopwatch_ctrl #(
  parameter int DBNC_CYCLES = 1000000,
  parameter int TICK_DIV    = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_ss,
  input  logic i_btn_clr,
  output logic o_enb,
  output logic o_clr,
  output logic o_running
);

  localparam int DW = $clog2(DBNC_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Bit 0 is the start/stop button, bit 1 is the clear button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    db_prev_q, db_prev_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enb_q, enb_d;
  logic          clr_q, clr_d;
  logic          running_q, running_d;

  logic          ss_press;
  logic          clr_press;

  assign btn_raw   = {i_btn_clr, i_btn_ss};
  assign ss_press  = press_q[0];
  assign clr_press = press_q[1];

  assign o_enb     = enb_q;
  assign o_clr     = clr_q;
  assign o_running = running_q;

  // Button conditioning: sync chain, debounce counter, registered rising-edge pulse.
  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    press_d   = db_q & ~db_prev_q;
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DW'(DBNC_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Conditioning registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear press always beats a simultaneous start/stop press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_press)     state_d = ST_IDLE;
        else if (ss_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_press)     state_d = ST_IDLE;
        else if (ss_press) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clr_press)     state_d = ST_IDLE;
        else if (ss_press) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: prescaler advances only in RUN, holds in PAUSE, zero in IDLE or on clear.
  always_comb begin
    presc_d   = presc_q;
    enb_d     = 1'b0;
    clr_d     = clr_press;
    running_d = (state_d == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
      end
      ST_RUN: begin
        if (presc_q == PW'(TICK_DIV - 1)) begin
          enb_d   = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        presc_d = presc_q;
      end
      default: begin
        presc_d = '0;
      end
    endcase
    if (clr_press) begin
      presc_d = '0;
    end
  end

  // Registered outputs and prescaler.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_q   <= '0;
      enb_q     <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      enb_q     <= enb_d;
      clr_q     <= clr_d;
      running_q <= running_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DBNC_CYCLES=4, TICK_DIV=5.
// Inputs change and outputs are sampled on the falling clock edge; cyc counts
// falling edges, so an output seen at cyc==N was produced by rising edge N.
module tb_stopwatch_ctrl;

  localparam int DBNC = 4;
  localparam int TDIV = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_btn_ss = 1'b0;
  logic i_btn_clr = 1'b0;
  logic o_enb;
  logic o_clr;
  logic o_running;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;

  stopwatch_ctrl #(
    .DBNC_CYCLES(DBNC),
    .TICK_DIV(TDIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_btn_ss(i_btn_ss),
    .i_btn_clr(i_btn_clr),
    .o_enb(o_enb),
    .o_clr(o_clr),
    .o_running(o_running)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected sequence to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_running(input logic val, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (o_running === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_enb(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (o_enb === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int highs;
    rst = 1'b0;
    i_btn_ss = 1'b1;
    i_btn_clr = 1'b1;
    repeat (3) step();
    n_checks++;
    if (o_enb !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_enb: got %b, expected 0", o_enb);
    end
    n_checks++;
    if (o_clr !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_clr: got %b, expected 0", o_clr);
    end
    n_checks++;
    if (o_running !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_running: got %b, expected 0", o_running);
    end
    rst = 1'b1;
    i_btn_ss = 1'b0;
    i_btn_clr = 1'b0;
    highs = 0;
    repeat (20) begin
      step();
      if ((o_enb !== 1'b0) || (o_clr !== 1'b0) || (o_running !== 1'b0)) highs++;
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_quiet: got %0d active cycles, expected 0", highs);
    end
  endtask

  task automatic test_debounce();
    int highs;
    int c0;
    int at;
    i_btn_ss = 1'b1;
    repeat (3) step();
    i_btn_ss = 1'b0;
    highs = 0;
    repeat (20) begin
      step();
      if (o_running !== 1'b0) highs++;
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++;
      $display("[TB] FAIL glitch_no_start: got %0d running cycles, expected 0", highs);
    end
    c0 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b1, 12, at);
    n_checks++;
    if (at < 0 || (at - c0) !== 8) begin
      n_fail++;
      $display("[TB] FAIL start_latency: got %0d, expected 8", (at < 0) ? -1 : at - c0);
    end
    t0 = at;
    repeat (2) step();
    i_btn_ss = 1'b0;
  endtask

  task automatic test_run_ticks();
    int at;
    int first;
    int ticks;
    int bad;
    logic exp_enb;
    wait_enb(10, at);
    n_checks++;
    if (at < 0 || (at - t0) !== 5) begin
      n_fail++;
      $display("[TB] FAIL first_tick: got %0d, expected 5", (at < 0) ? -1 : at - t0);
    end
    first = at;
    ticks = (at < 0) ? 0 : 1;
    bad = 0;
    for (int k = 1; k < 60; k++) begin
      step();
      exp_enb = (((cyc - first) % TDIV) == 0);
      if (o_enb === 1'b1) ticks++;
      if (o_enb !== exp_enb) bad++;
    end
    n_checks++;
    if (ticks !== 12) begin
      n_fail++;
      $display("[TB] FAIL tick_count: got %0d, expected 12", ticks);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL tick_spacing: got %0d off-phase cycles, expected 0", bad);
    end
    n_checks++;
    if (o_running !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL running_level: got %b, expected 1", o_running);
    end
  endtask

  task automatic test_pause_resume();
    int c0;
    int c1;
    int at;
    int r;
    int enbs;
    for (int k = 0; k < TDIV && (((cyc + 8 - t0) % TDIV) != 2); k++) step();
    c0 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b0, 12, at);
    n_checks++;
    if (at < 0 || (at - c0) !== 8) begin
      n_fail++;
      $display("[TB] FAIL pause_latency: got %0d, expected 8", (at < 0) ? -1 : at - c0);
    end
    i_btn_ss = 1'b0;
    enbs = 0;
    repeat (40) begin
      step();
      if (o_enb !== 1'b0) enbs++;
    end
    n_checks++;
    if (enbs !== 0) begin
      n_fail++;
      $display("[TB] FAIL pause_no_tick: got %0d ticks, expected 0", enbs);
    end
    n_checks++;
    if (o_running !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pause_running: got %b, expected 0", o_running);
    end
    c1 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b1, 12, at);
    n_checks++;
    if (at < 0 || (at - c1) !== 8) begin
      n_fail++;
      $display("[TB] FAIL resume_latency: got %0d, expected 8", (at < 0) ? -1 : at - c1);
    end
    i_btn_ss = 1'b0;
    r = at;
    wait_enb(10, at);
    n_checks++;
    if (at < 0 || (at - r) !== 3) begin
      n_fail++;
      $display("[TB] FAIL resume_phase: got %0d, expected 3", (at < 0) ? -1 : at - r);
    end
    t0 = at - TDIV;
  endtask

  task automatic test_clear_from_run();
    int c2;
    int c3;
    int clrs;
    int clr_at;
    int enb_after;
    int run_bad;
    int at;
    int r;
    c2 = cyc;
    i_btn_clr = 1'b1;
    clrs = 0;
    clr_at = -1;
    enb_after = 0;
    run_bad = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 10) i_btn_clr = 1'b0;
      if (o_clr === 1'b1) begin
        clrs++;
        if (clr_at < 0) clr_at = cyc;
      end
      if (clr_at >= 0 && cyc > clr_at && o_enb !== 1'b0) enb_after++;
      if (clr_at >= 0 && o_running !== 1'b0) run_bad++;
    end
    n_checks++;
    if (clrs !== 1) begin
      n_fail++;
      $display("[TB] FAIL clear_pulse_width: got %0d cycles, expected 1", clrs);
    end
    n_checks++;
    if (clr_at < 0 || (clr_at - c2) !== 8) begin
      n_fail++;
      $display("[TB] FAIL clear_latency: got %0d, expected 8", (clr_at < 0) ? -1 : clr_at - c2);
    end
    n_checks++;
    if (enb_after !== 0) begin
      n_fail++;
      $display("[TB] FAIL clear_no_tick: got %0d ticks, expected 0", enb_after);
    end
    n_checks++;
    if (run_bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL clear_running: got %0d running cycles, expected 0", run_bad);
    end
    c3 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b1, 12, at);
    n_checks++;
    if (at < 0 || (at - c3) !== 8) begin
      n_fail++;
      $display("[TB] FAIL restart_latency: got %0d, expected 8", (at < 0) ? -1 : at - c3);
    end
    i_btn_ss = 1'b0;
    r = at;
    wait_enb(10, at);
    n_checks++;
    if (at < 0 || (at - r) !== 5) begin
      n_fail++;
      $display("[TB] FAIL restart_phase: got %0d, expected 5", (at < 0) ? -1 : at - r);
    end
    t0 = r;
  endtask

  task automatic test_simultaneous();
    int c0;
    int c1;
    int c3;
    int at;
    int r;
    int clrs;
    int clr_at;
    int run_hi;
    int enbs;
    for (int k = 0; k < TDIV && (((cyc + 8 - t0) % TDIV) != 2); k++) step();
    c0 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b0, 12, at);
    n_checks++;
    if (at < 0 || (at - c0) !== 8) begin
      n_fail++;
      $display("[TB] FAIL sim_pause_latency: got %0d, expected 8", (at < 0) ? -1 : at - c0);
    end
    i_btn_ss = 1'b0;
    repeat (20) step();
    c1 = cyc;
    i_btn_ss = 1'b1;
    i_btn_clr = 1'b1;
    clrs = 0;
    clr_at = -1;
    run_hi = 0;
    enbs = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 10) begin
        i_btn_ss = 1'b0;
        i_btn_clr = 1'b0;
      end
      if (o_clr === 1'b1) begin
        clrs++;
        if (clr_at < 0) clr_at = cyc;
      end
      if (o_running !== 1'b0) run_hi++;
      if (o_enb !== 1'b0) enbs++;
    end
    n_checks++;
    if (clrs !== 1) begin
      n_fail++;
      $display("[TB] FAIL sim_clear_pulse: got %0d cycles, expected 1", clrs);
    end
    n_checks++;
    if (clr_at < 0 || (clr_at - c1) !== 8) begin
      n_fail++;
      $display("[TB] FAIL sim_clear_latency: got %0d, expected 8", (clr_at < 0) ? -1 : clr_at - c1);
    end
    n_checks++;
    if (run_hi !== 0) begin
      n_fail++;
      $display("[TB] FAIL sim_ss_ignored: got %0d running cycles, expected 0", run_hi);
    end
    n_checks++;
    if (enbs !== 0) begin
      n_fail++;
      $display("[TB] FAIL sim_no_tick: got %0d ticks, expected 0", enbs);
    end
    c3 = cyc;
    i_btn_ss = 1'b1;
    wait_running(1'b1, 12, at);
    n_checks++;
    if (at < 0 || (at - c3) !== 8) begin
      n_fail++;
      $display("[TB] FAIL sim_restart_latency: got %0d, expected 8", (at < 0) ? -1 : at - c3);
    end
    i_btn_ss = 1'b0;
    r = at;
    wait_enb(10, at);
    n_checks++;
    if (at < 0 || (at - r) !== 5) begin
      n_fail++;
      $display("[TB] FAIL sim_idle_phase: got %0d, expected 5", (at < 0) ? -1 : at - r);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_debounce();
    test_run_ticks();
    test_pause_resume();
    test_clear_from_run();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control stage directly upstream of the mod-10 digit counter chain in the stopwatch datapath.
- Conditions two raw push-buttons (start/stop, clear): synchronise, debounce, rising-edge detect.
- Runs an IDLE/RUN/PAUSE state machine.
- Produces the counter's enable tick (o_enb, one cycle per TICK_DIV clocks while running) and a one-cycle clear pulse (o_clr).

Parameters:
- DBNC_CYCLES, 1000000, consecutive clocks a synchronised button level must differ from the debounced level before it is accepted (20 ms at 50 MHz).
- TICK_DIV, 5000000, clocks per enable tick while running (10 Hz at 50 MHz); minimum 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset
- i_btn_ss  input  1  raw start/stop button, active high, asynchronous to clk
- i_btn_clr  input  1  raw clear button, active high, asynchronous to clk
- o_enb  output  1  one-cycle count-enable tick to the counter's i_enb
- o_clr  output  1  one-cycle clear pulse to the counter's i_clr
- o_running  output  1  high while state is RUN

Behaviour:
- Reset: clk and rst are fixed as one clock, synchronous active-low reset. rst low at a rising clk edge clears everything:
  - synchronisers, debounced levels, previous-level registers, debounce counters and prescaler go to 0;
  - state goes to IDLE;
  - o_enb=0, o_clr=0, o_running=0.
- Reset mid-operation: behaviour is identical; any pending tick or pulse is dropped.
- Synchroniser: 2-flop chain per button. Synchronised level s lags the raw input by 2 clocks.
- Debounce, per button:
  - Counter width is $clog2(DBNC_CYCLES+1).
  - While s == db, the counter is cleared.
  - While s != db, the counter increments. When it reaches DBNC_CYCLES-1 and s still differs, db takes s and the counter clears.
  - A glitch shorter than DBNC_CYCLES clocks never changes db.
- Edge detect: press = db & ~db_q, where db_q is db delayed 1 clock. press is high exactly one cycle per accepted press. Releases generate nothing.
- FSM (registered; evaluated on the press signals of the current cycle):
  - IDLE: ss_press -> RUN, prescaler loaded 0. clr_press -> stay IDLE, pulse o_clr.
  - RUN: ss_press -> PAUSE. clr_press -> IDLE, pulse o_clr, prescaler 0.
  - PAUSE: ss_press -> RUN; prescaler value is kept, so tick phase resumes. clr_press -> IDLE, pulse o_clr, prescaler 0.
  - Simultaneous ss_press and clr_press: clear wins. Next state is IDLE, o_clr pulses, ss_press is ignored.
- o_clr: registered. High for exactly the one cycle following the edge where clr_press was sampled.
- Prescaler:
  - Width $clog2(TICK_DIV). Counts 0..TICK_DIV-1 and wraps to 0, only while state == RUN. Holds in PAUSE; is 0 in IDLE.
  - o_enb is registered: high for one cycle following each edge where state == RUN and the prescaler == TICK_DIV-1.
  - First tick after IDLE->RUN arrives TICK_DIV clocks after the state becomes RUN.
  - Tick on the same cycle as ss_press (RUN->PAUSE): the tick is still issued, since it was sampled in RUN.
  - No o_enb is ever issued in PAUSE or IDLE.
- o_running: registered, equals (state == RUN).
- End-to-end latency: from a raw press held stable to the state change is 2 sync + DBNC_CYCLES debounce + 1 edge + 1 FSM clocks.

Test Plan (bench uses DBNC_CYCLES=4, TICK_DIV=5):
1. Reset: rst=0 for 3 clocks with both buttons high -> o_enb=o_clr=o_running=0. After release with buttons low, state stays IDLE and no pulses appear.
2. Debounce: i_btn_ss high for 3 clocks then low -> no press, o_running stays 0. Hold high for 10 clocks -> o_running rises at clock 2+4+1+1=8 after the raw rise.
3. Run ticks: after start, o_enb pulses once every 5 clocks, first at 5 clocks after o_running rises. Count 12 ticks in 60 clocks -> exactly 12 single-cycle pulses.
4. Pause/resume phase: pause when the prescaler is 2 -> no o_enb while paused for 40 clocks. Resume -> first tick 3 clocks after o_running reasserts.
5. Clear from RUN: clr press -> o_clr high for exactly 1 cycle, o_running=0, state IDLE, no further o_enb. A next start restarts with full 5-clock phase.
6. Simultaneous: both buttons' debounced edges on the same cycle while in PAUSE -> o_clr pulses once, state IDLE, o_running stays 0.
